cpu_bus_decoder: RTL and testbench

Parametrised successor to the `cpu_bus` bundle, for use with the Z80 CPU bus of the Spectrum-compatible core. It synchronises the raw, asynchronous Z80 control signals to `clk28` and latches address and data once per bus cycle. It classifies each cycle as I/O, memory or interrupt-acknowledge, and decodes it against `CHANNELS` programmable match/mask windows. Each matching cycle produces exactly one single-clock read or write strobe. The block sits between the CPU pins and the port/memory peripherals (ULA port, AY, paging registers), replacing ad-hoc per-peripheral decoding.

---
 rtl/common_pkg.sv | 25 ++
 rtl/bus_sync.sv | 30 +++
 rtl/cpu_bus_decoder.sv | 159 +++++++++++++++
 tb/tb_cpu_bus_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared bus-decoder types: state encoding, channel limit and control-bit layout.
`default_nettype none

package common;

  localparam int BUS_CH_MAX = 16;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_ACTIVE  = 2'd1,
    BUS_HOLDOFF = 2'd2
  } bus_state_t;

  // Bit positions of the raw active-low controls inside the synchroniser word
  localparam int CTRL_W      = 6;
  localparam int CTRL_IORQ_N = 5;
  localparam int CTRL_MREQ_N = 4;
  localparam int CTRL_M1_N   = 3;
  localparam int CTRL_RFSH_N = 2;
  localparam int CTRL_RD_N   = 1;
  localparam int CTRL_WR_N   = 0;

endpackage

`default_nettype wire

// File: rtl/bus_sync.sv
// N-stage, W-bit flop synchroniser with a programmable reset value.
`default_nettype none

module bus_sync #(
  parameter int             STAGES    = 2,
  parameter int             W         = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cpu_bus_decoder.sv
// Z80 bus cycle synchroniser, classifier and programmable match/mask window decoder.
// Produces one registered read/write strobe per decoded bus cycle.
`default_nettype none

module cpu_bus_decoder
  import common::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk28,
  input  logic                   rst,
  input  logic [15:0]            bus_a,
  input  logic [7:0]             bus_d,
  input  logic                   bus_iorq_n,
  input  logic                   bus_mreq_n,
  input  logic                   bus_m1_n,
  input  logic                   bus_rfsh_n,
  input  logic                   bus_rd_n,
  input  logic                   bus_wr_n,
  input  logic [CHANNELS-1:0]    ch_en,
  input  logic [CHANNELS-1:0]    ch_mem,
  input  logic [CHANNELS*16-1:0] ch_match,
  input  logic [CHANNELS*16-1:0] ch_mask,
  output logic [15:0]            a_reg,
  output logic [7:0]             d_reg,
  output logic                   ioreq,
  output logic                   memreq,
  output logic                   inta,
  output logic [CHANNELS-1:0]    hit,
  output logic [CHANNELS-1:0]    rd_stb,
  output logic [CHANNELS-1:0]    wr_stb
);

  logic [CTRL_W-1:0] w_ctrl_n;

  bus_sync #(
    .STAGES    (SYNC_STAGES),
    .W         (CTRL_W),
    .RESET_VAL ({CTRL_W{1'b1}})
  ) u_ctrl_sync (
    .clk (clk28),
    .rst (rst),
    .d   ({bus_iorq_n, bus_mreq_n, bus_m1_n, bus_rfsh_n, bus_rd_n, bus_wr_n}),
    .q   (w_ctrl_n)
  );

  logic w_iorq, w_mreq, w_m1, w_rfsh_n, w_rd, w_wr;
  assign w_iorq   = ~w_ctrl_n[CTRL_IORQ_N];
  assign w_mreq   = ~w_ctrl_n[CTRL_MREQ_N];
  assign w_m1     = ~w_ctrl_n[CTRL_M1_N];
  assign w_rfsh_n =  w_ctrl_n[CTRL_RFSH_N];
  assign w_rd     = ~w_ctrl_n[CTRL_RD_N];
  assign w_wr     = ~w_ctrl_n[CTRL_WR_N];

  logic w_is_io, w_is_inta, w_is_mem, w_any;
  assign w_is_io   = w_iorq & ~w_m1 & (w_rd | w_wr);
  assign w_is_inta = w_iorq & w_m1;
  assign w_is_mem  = w_mreq & w_rfsh_n & (w_rd | w_wr) & ~w_is_io & ~w_is_inta;
  assign w_any     = w_is_io | w_is_inta | w_is_mem;

  // The synchroniser resets to "inactive", so HOLDOFF waits for it to refill
  // before deciding whether a cycle was already in flight across reset.
  logic [1:0] r_fill;
  logic       w_filled;
  assign w_filled = (r_fill == 2'(SYNC_STAGES));

  always_ff @(posedge clk28) begin
    if (rst)            r_fill <= 2'd0;
    else if (!w_filled) r_fill <= r_fill + 2'd1;
  end

  bus_state_t r_state, w_state_next;
  logic       w_entry, w_exit;

  always_ff @(posedge clk28) begin
    if (rst) r_state <= BUS_HOLDOFF;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_entry      = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (w_any) begin
          w_state_next = BUS_ACTIVE;
          w_entry      = 1'b1;
        end
      end
      BUS_ACTIVE: begin
        if (!w_any) begin
          w_state_next = BUS_IDLE;
          w_exit       = 1'b1;
        end
      end
      BUS_HOLDOFF: begin
        if (w_filled && !w_any) w_state_next = BUS_IDLE;
      end
      default: w_state_next = BUS_IDLE;
    endcase
  end

  // Lowest-index matching window wins; INTA matches no window type.
  logic [CHANNELS-1:0] w_hit;
  logic                w_found;
  logic                w_type_ok;
  logic [15:0]         w_diff;

  always_comb begin
    w_hit     = '0;
    w_found   = 1'b0;
    w_type_ok = 1'b0;
    w_diff    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_type_ok = ch_mem[i] ? w_is_mem : w_is_io;
      w_diff    = (bus_a ^ ch_match[16*i +: 16]) & ch_mask[16*i +: 16];
      if (!w_found && ch_en[i] && w_type_ok && (w_diff == 16'h0000)) begin
        w_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      a_reg  <= '0;
      d_reg  <= '0;
      ioreq  <= 1'b0;
      memreq <= 1'b0;
      inta   <= 1'b0;
      hit    <= '0;
      rd_stb <= '0;
      wr_stb <= '0;
    end else begin
      rd_stb <= '0;
      wr_stb <= '0;
      if (w_entry) begin
        a_reg  <= bus_a;
        if (w_wr && !w_is_inta) d_reg <= bus_d;
        ioreq  <= w_is_io;
        memreq <= w_is_mem;
        inta   <= w_is_inta;
        hit    <= w_hit;
        wr_stb <= w_wr ? w_hit : '0;
        rd_stb <= (w_rd && !w_wr) ? w_hit : '0;
      end else if (w_exit) begin
        ioreq  <= 1'b0;
        memreq <= 1'b0;
        inta   <= 1'b0;
        hit    <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_decoder.sv
// Directed scoreboard bench for cpu_bus_decoder: stimulus pushes expectations, a monitor checks.
`default_nettype none

module tb_cpu_bus_decoder;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic          clk28 = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   bus_a = '0;
  logic [7:0]    bus_d = '0;
  logic          bus_iorq_n = 1'b1, bus_mreq_n = 1'b1, bus_m1_n = 1'b1;
  logic          bus_rfsh_n = 1'b1, bus_rd_n = 1'b1, bus_wr_n = 1'b1;
  logic [CH-1:0] ch_en, ch_mem;
  logic [CH*16-1:0] ch_match, ch_mask;
  logic [15:0]   a_reg;
  logic [7:0]    d_reg;
  logic          ioreq, memreq, inta;
  logic [CH-1:0] hit, rd_stb, wr_stb;

  cpu_bus_decoder #(.CHANNELS(CH), .SYNC_STAGES(SS)) dut (
    .clk28(clk28), .rst(rst), .bus_a(bus_a), .bus_d(bus_d),
    .bus_iorq_n(bus_iorq_n), .bus_mreq_n(bus_mreq_n), .bus_m1_n(bus_m1_n),
    .bus_rfsh_n(bus_rfsh_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .ch_en(ch_en), .ch_mem(ch_mem), .ch_match(ch_match), .ch_mask(ch_mask),
    .a_reg(a_reg), .d_reg(d_reg), .ioreq(ioreq), .memreq(memreq), .inta(inta),
    .hit(hit), .rd_stb(rd_stb), .wr_stb(wr_stb)
  );

  always #5 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  typ;   // {inta, memreq, ioreq}
    logic [3:0]  hit;
    logic [3:0]  rd;
    logic [3:0]  wr;
  } exp_t;

  exp_t q_ev[$];
  int   q_end[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] last_d = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  localparam logic [CH*16-1:0] MATCH_CFG = {16'h4000, 16'h0000, 16'h7FFD, 16'h00FE};
  localparam logic [CH*16-1:0] MASK_CFG  = {16'hC000, 16'h0000, 16'h8002, 16'h00FF};

  // Monitor: an output event is the rising edge of any cycle-type level.
  logic mon_act;
  logic prev_act = 1'b0;
  exp_t cur;

  always @(negedge clk28) begin
    mon_act = ioreq | memreq | inta;
    if (rst) begin
      prev_act = 1'b0;
    end else begin
      if (mon_act && !prev_act) begin
        if (q_ev.size() == 0) begin
          chk("unexpected_entry", 32'd1, 32'd0);
        end else begin
          cur = q_ev.pop_front();
          chk("entry_latency", cyc, cur.cyc);
          chk("entry_type", {inta, memreq, ioreq}, cur.typ);
          chk("entry_a_reg", a_reg, cur.a);
          chk("entry_d_reg", d_reg, cur.d);
          chk("entry_hit", hit, cur.hit);
          chk("entry_rd_stb", rd_stb, cur.rd);
          chk("entry_wr_stb", wr_stb, cur.wr);
        end
      end else if (mon_act) begin
        chk("held_a_reg", a_reg, cur.a);
        chk("held_hit", hit, cur.hit);
        chk("held_stb_zero", {rd_stb, wr_stb}, 32'd0);
      end else begin
        chk("idle_outputs_zero", {hit, rd_stb, wr_stb}, 32'd0);
      end
      if (!mon_act && prev_act) begin
        if (q_end.size() == 0) chk("unexpected_exit", 32'd1, 32'd0);
        else                   chk("exit_latency", cyc, q_end.pop_front());
      end
      prev_act = mon_act;
    end
  end

  task automatic release_bus();
    bus_iorq_n = 1'b1; bus_mreq_n = 1'b1; bus_m1_n = 1'b1;
    bus_rfsh_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
  endtask

  task automatic run_cycle(input logic iorq_n, input logic mreq_n, input logic m1_n,
                           input logic rfsh_n, input logic rd_n, input logic wr_n,
                           input logic [15:0] a, input logic [7:0] d,
                           input logic [2:0] typ, input logic [3:0] exp_hit,
                           input int hold, input bit disturb);
    exp_t e;
    @(negedge clk28); #1;
    bus_a = a; bus_d = d;
    bus_iorq_n = iorq_n; bus_mreq_n = mreq_n; bus_m1_n = m1_n;
    bus_rfsh_n = rfsh_n; bus_rd_n = rd_n; bus_wr_n = wr_n;
    if (typ != 3'b000) begin
      if (!wr_n && typ != 3'b100) last_d = d;
      e.cyc = cyc + LAT;
      e.a   = a;
      e.d   = last_d;
      e.typ = typ;
      e.hit = exp_hit;
      e.wr  = !wr_n ? exp_hit : 4'b0000;
      e.rd  = (!rd_n && wr_n) ? exp_hit : 4'b0000;
      q_ev.push_back(e);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk28);
      if (disturb && k == hold / 2) begin
        #1;
        bus_a = 16'hFFFF;
        ch_en = 4'b0000;
        ch_match[15:0] = 16'h1234;
      end
    end
    if (typ == 3'b000) chk("no_cycle_type", {inta, memreq, ioreq}, 32'd0);
    #1;
    release_bus();
    if (typ != 3'b000) q_end.push_back(cyc + LAT);
    ch_en = 4'b1111;
    ch_match = MATCH_CFG;
    repeat (3) @(negedge clk28);
  endtask

  initial begin
    ch_en    = 4'b1111;
    ch_mem   = 4'b1000;
    ch_match = MATCH_CFG;
    ch_mask  = MASK_CFG;
    repeat (3) @(negedge clk28);
    chk("reset_a_reg", a_reg, 32'h0);
    chk("reset_d_reg", d_reg, 32'h0);
    chk("reset_levels", {inta, memreq, ioreq}, 32'h0);
    chk("reset_hit_stb", {hit, rd_stb, wr_stb}, 32'h0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk28);

    // iorq mreq m1 rfsh rd wr   addr     data   type    hit
    run_cycle(0, 1, 1, 1, 1, 0, 16'h12FE, 8'h07, 3'b001, 4'b0001, 4, 0);  // I/O write port 0x12FE
    run_cycle(0, 1, 1, 1, 0, 1, 16'h7FFD, 8'h00, 3'b001, 4'b0010, 4, 0);  // overlap: ch1 beats ch2
    run_cycle(1, 0, 1, 1, 0, 1, 16'h5800, 8'h00, 3'b010, 4'b1000, 4, 0);  // memory read
    run_cycle(1, 0, 1, 0, 0, 1, 16'h5800, 8'h00, 3'b000, 4'b0000, 5, 0);  // refresh: ignored
    run_cycle(0, 1, 0, 1, 1, 1, 16'h0038, 8'h00, 3'b100, 4'b0000, 4, 0);  // INTA
    run_cycle(0, 1, 1, 1, 0, 1, 16'h00FF, 8'h00, 3'b001, 4'b0100, 4, 0);  // mask 0 catch-all
    run_cycle(1, 0, 1, 1, 1, 0, 16'hC000, 8'hA5, 3'b010, 4'b0000, 4, 0);  // mem write, no window
    run_cycle(0, 1, 1, 1, 0, 0, 16'h01FE, 8'h3C, 3'b001, 4'b0001, 4, 0);  // rd+wr: write wins
    run_cycle(0, 1, 1, 1, 0, 1, 16'h12FE, 8'h00, 3'b001, 4'b0001, 20, 1); // long read, disturbed

    ch_en = 4'b1110;  // disabled ch0 falls through to ch2
    run_cycle(0, 1, 1, 1, 1, 0, 16'h12FE, 8'h11, 3'b001, 4'b0100, 4, 0);

    // Reset in the middle of an I/O write, released while the write is still low
    begin
      exp_t e;
      @(negedge clk28); #1;
      bus_a = 16'h12FE; bus_d = 8'h55; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
      last_d = 8'h55;
      e.cyc = cyc + LAT; e.a = 16'h12FE; e.d = 8'h55; e.typ = 3'b001;
      e.hit = 4'b0001; e.wr = 4'b0001; e.rd = 4'b0000;
      q_ev.push_back(e);
      repeat (LAT + 1) @(negedge clk28);
      #1 rst = 1'b1;
      @(negedge clk28);
      last_d = 8'h00;
      chk("midrst_a_reg", a_reg, 32'h0);
      chk("midrst_d_reg", d_reg, 32'h0);
      chk("midrst_outputs", {inta, memreq, ioreq, hit, rd_stb, wr_stb}, 32'h0);
      #1 rst = 1'b0;
      repeat (8) @(negedge clk28);
      chk("holdoff_levels", {inta, memreq, ioreq}, 32'h0);
      #1 release_bus();
      repeat (4) @(negedge clk28);
    end
    run_cycle(0, 1, 1, 1, 1, 0, 16'h00FE, 8'h99, 3'b001, 4'b0001, 4, 0);

    repeat (5) @(negedge clk28);
    chk("pending_entries", q_ev.size(), 32'd0);
    chk("pending_exits", q_end.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
